// File: rtl/apb_gpio_master_arb.sv
// Round-robin arbiter plus APB master sequencer sharing one APB port to the GPIO slave.
// One transfer in flight at a time; read data and error status return to the winning requester.
module apb_gpio_master_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [AW-1:0]      PADDR,
    output logic [DW-1:0]      PWDATA,
    input  logic [DW-1:0]      PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    localparam int unsigned GW  = $clog2(NREQ);
    localparam int unsigned GW1 = GW + 1;
    localparam int unsigned CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   cur;
    logic [GW-1:0]   pick;
    logic [GW1-1:0]  cand;
    logic            found;
    logic            any_req;
    logic            grant;
    logic            done_ok;
    logic            done_abort;
    logic [CW-1:0]   cnt;

    // Requests are ignored while reset is held so that every output stays low.
    assign any_req = (|req_valid) & ~PRESET;

    // Search starts one past the previous winner and wraps around.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = {1'b0, last_grant} + GW1'(i);
            if (cand >= GW1'(NREQ)) begin
                cand = cand - GW1'(NREQ);
            end
            if (!found && req_valid[cand[GW-1:0]]) begin
                found = 1'b1;
                pick  = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        done_ok    = 1'b0;
        done_abort = 1'b0;
        req_ready  = '0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    grant     = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    done_ok = 1'b1;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    done_abort = 1'b1;
                end
                if (done_ok || done_abort) begin
                    if (any_req) begin
                        grant     = 1'b1;
                        state_nxt = SETUP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (grant) begin
            req_ready[pick] = 1'b1;
        end
    end

    // Decoded from the state register so reset drops them immediately.
    assign PSEL    = (state == SETUP) || (state == ACCESS);
    assign PENABLE = (state == ACCESS);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            last_grant <= GW'(NREQ - 1);
            cur        <= '0;
            cnt        <= '0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= '0;
            if (grant) begin
                last_grant <= pick;
                cur        <= pick;
                PWRITE     <= req_write[pick];
                PADDR      <= req_addr[int'(pick)*AW +: AW];
                PWDATA     <= req_write[pick] ? req_wdata[int'(pick)*DW +: DW] : '0;
            end
            if (state == SETUP) begin
                cnt <= '0;
            end else if (state == ACCESS && !PREADY) begin
                cnt <= cnt + 1'b1;
            end
            if (done_ok) begin
                rsp_valid[cur] <= 1'b1;
                rsp_rdata      <= PWRITE ? '0 : PRDATA;
                rsp_err        <= PSLVERR;
            end else if (done_abort) begin
                rsp_valid[cur] <= 1'b1;
                rsp_rdata      <= '0;
                rsp_err        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_gpio_master_arb.sv
// Self-checking bench for apb_gpio_master_arb: directed scenarios plus a randomized
// run checked against a transaction-level model of arbitration and APB responses.
module tb_apb_gpio_master_arb;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 16;

    logic               PCLK = 1'b0;
    logic               PRESET;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic               PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [AW-1:0]      PADDR;
    logic [DW-1:0]      PWDATA;
    logic [DW-1:0]      PRDATA;
    logic               PREADY;
    logic               PSLVERR;

    int checks   = 0;
    int failures = 0;

    always #5 PCLK = ~PCLK;

    apb_gpio_master_arb #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic clear_inputs;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
    endtask

    task automatic test_reset;
        PRESET = 1'b1;
        clear_inputs();
        req_valid = 4'hF;
        tick();
        tick();
        #1;
        checks++; if (PSEL !== 1'b0) begin failures++; $display("FAIL reset_psel got=%0h exp=0", PSEL); end
        checks++; if (PENABLE !== 1'b0) begin failures++; $display("FAIL reset_penable got=%0h exp=0", PENABLE); end
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%0h exp=0", req_ready); end
        checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
        checks++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0) begin failures++; $display("FAIL reset_apb_bus got=%0h/%0h/%0h exp=0/0/0", PADDR, PWDATA, PWRITE); end
        checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp got=%0h/%0h exp=0/0", rsp_rdata, rsp_err); end
        req_valid = '0;
        PRESET    = 1'b0;
    endtask

    task automatic test_single_write;
        tick();
        req_write[0]      = 1'b1;
        req_addr[31:0]    = 32'h0000_0004;
        req_wdata[31:0]   = 32'hA5A5_0001;
        req_valid         = 4'b0001;
        PREADY            = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL wr_req_ready got=%0h exp=1", req_ready); end
        checks++; if (PSEL !== 1'b0) begin failures++; $display("FAIL wr_c0_psel got=%0h exp=0", PSEL); end
        tick();
        req_valid = '0;
        PREADY    = 1'b1;
        #1;
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin failures++; $display("FAIL wr_setup got=%0h/%0h exp=1/0", PSEL, PENABLE); end
        checks++; if (PADDR !== 32'h4 || PWRITE !== 1'b1 || PWDATA !== 32'hA5A5_0001) begin failures++; $display("FAIL wr_setup_bus got=%0h/%0h/%0h exp=4/1/a5a50001", PADDR, PWRITE, PWDATA); end
        tick();
        #1;
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin failures++; $display("FAIL wr_access got=%0h/%0h exp=1/1", PSEL, PENABLE); end
        checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL wr_early_rsp got=%0h exp=0", rsp_valid); end
        tick();
        PREADY = 1'b0;
        #1;
        checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0) begin failures++; $display("FAIL wr_rsp got=%0h/%0h exp=1/0", rsp_valid, rsp_err); end
        checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin failures++; $display("FAIL wr_after got=%0h/%0h exp=0/0", PSEL, PENABLE); end
        tick();
        #1;
        checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL wr_rsp_pulse got=%0h exp=0", rsp_valid); end
    endtask

    task automatic test_read_wait;
        tick();
        req_write[2]     = 1'b0;
        req_addr[95:64]  = 32'h0000_0008;
        req_wdata[95:64] = $urandom;
        req_valid        = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL rd_req_ready got=%0h exp=4", req_ready); end
        tick();
        req_valid = '0;
        PREADY    = 1'b0;
        #1;
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h8 || PWRITE !== 1'b0 || PWDATA !== 32'h0) begin failures++; $display("FAIL rd_setup got=%0h/%0h/%0h/%0h/%0h exp=1/0/8/0/0", PSEL, PENABLE, PADDR, PWRITE, PWDATA); end
        for (int w = 0; w < 4; w++) begin
            tick();
            PREADY = (w == 3);
            PRDATA = (w == 3) ? 32'h0000_00FF : $urandom;
            #1;
            checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 32'h8) begin failures++; $display("FAIL rd_wait%0d got=%0h/%0h/%0h exp=1/1/8", w, PSEL, PENABLE, PADDR); end
            checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL rd_wait_rsp%0d got=%0h exp=0", w, rsp_valid); end
        end
        tick();
        PREADY = 1'b0;
        PRDATA = $urandom;
        #1;
        checks++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 32'hFF || rsp_err !== 1'b0) begin failures++; $display("FAIL rd_rsp got=%0h/%0h/%0h exp=4/ff/0", rsp_valid, rsp_rdata, rsp_err); end
        checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin failures++; $display("FAIL rd_after got=%0h/%0h exp=0/0", PSEL, PENABLE); end
        tick();
        #1;
        checks++; if (rsp_valid !== 4'b0 || rsp_rdata !== 32'hFF) begin failures++; $display("FAIL rd_hold got=%0h/%0h exp=0/ff", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_back_to_back;
        int          g;
        int          prev;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic        s_write;
        logic        p_write;
        logic [31:0] exp_rd;
        PRESET = 1'b1;
        clear_inputs();
        tick();
        PRESET = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = $urandom;
            req_wdata[i*DW +: DW] = $urandom;
            req_write[i]          = 1'($urandom_range(0, 1));
        end
        req_valid = 4'hF;
        PREADY    = 1'b1;
        g         = 0;
        prev      = 0;
        p_write   = 1'b0;
        exp_rd    = '0;
        for (int k = 0; k < 5; k++) begin
            PRDATA = $urandom;
            #1;
            checks++; if (req_ready !== 4'(1 << g)) begin failures++; $display("FAIL b2b_grant%0d got=%0h exp=%0h", k, req_ready, 4'(1 << g)); end
            if (k > 0) begin
                checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin failures++; $display("FAIL b2b_access%0d got=%0h/%0h exp=1/1", k, PSEL, PENABLE); end
                exp_rd = p_write ? 32'h0 : PRDATA;
            end
            s_addr  = req_addr[g*AW +: AW];
            s_wdata = req_wdata[g*DW +: DW];
            s_write = req_write[g];
            tick();
            req_addr[g*AW +: AW]  = $urandom;
            req_wdata[g*DW +: DW] = $urandom;
            req_write[g]          = 1'($urandom_range(0, 1));
            #1;
            checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin failures++; $display("FAIL b2b_setup%0d got=%0h/%0h exp=1/0", k, PSEL, PENABLE); end
            checks++; if (PADDR !== s_addr || PWRITE !== s_write || PWDATA !== (s_write ? s_wdata : 32'h0)) begin failures++; $display("FAIL b2b_bus%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", k, PADDR, PWRITE, PWDATA, s_addr, s_write, s_write ? s_wdata : 32'h0); end
            if (k > 0) begin
                checks++; if (rsp_valid !== 4'(1 << prev) || rsp_rdata !== exp_rd || rsp_err !== 1'b0) begin failures++; $display("FAIL b2b_rsp%0d got=%0h/%0h/%0h exp=%0h/%0h/0", k, rsp_valid, rsp_rdata, rsp_err, 4'(1 << prev), exp_rd); end
            end
            tick();
            prev    = g;
            p_write = s_write;
            g       = (g + 1) % NREQ;
        end
        req_valid = '0;
        PRDATA    = $urandom;
        #1;
        checks++; if (req_ready !== 4'b0 || PENABLE !== 1'b1) begin failures++; $display("FAIL b2b_last got=%0h/%0h exp=0/1", req_ready, PENABLE); end
        exp_rd = p_write ? 32'h0 : PRDATA;
        tick();
        PREADY = 1'b0;
        #1;
        checks++; if (rsp_valid !== 4'(1 << prev) || rsp_rdata !== exp_rd || PSEL !== 1'b0 || PENABLE !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0h/%0h/%0h/%0h exp=%0h/%0h/0/0", rsp_valid, rsp_rdata, PSEL, PENABLE, 4'(1 << prev), exp_rd); end
    endtask

    task automatic test_timeout;
        logic [31:0] a;
        logic [31:0] d;
        tick();
        req_write[3]      = 1'b0;
        req_addr[127:96]  = $urandom;
        req_valid         = 4'b1000;
        PREADY            = 1'b0;
        PSLVERR           = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL to_grant got=%0h exp=8", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin failures++; $display("FAIL to_setup got=%0h/%0h exp=1/0", PSEL, PENABLE); end
        for (int n = 0; n < TO; n++) begin
            tick();
            PRDATA = $urandom | 32'h1;
            #1;
            checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || rsp_valid !== 4'b0) begin failures++; $display("FAIL to_access%0d got=%0h/%0h/%0h exp=1/1/0", n, PSEL, PENABLE, rsp_valid); end
        end
        tick();
        #1;
        checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin failures++; $display("FAIL to_abort_bus got=%0h/%0h exp=0/0", PSEL, PENABLE); end
        checks++; if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL to_abort_rsp got=%0h/%0h/%0h exp=8/1/0", rsp_valid, rsp_err, rsp_rdata); end
        tick();
        a               = $urandom;
        d               = $urandom;
        req_write[1]    = 1'b0;
        req_addr[63:32] = a;
        req_valid       = 4'b0010;
        PREADY          = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL to_next_grant got=%0h exp=2", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (PSEL !== 1'b1 || PADDR !== a) begin failures++; $display("FAIL to_next_setup got=%0h/%0h exp=1/%0h", PSEL, PADDR, a); end
        tick();
        PRDATA = d;
        #1;
        tick();
        PREADY = 1'b0;
        #1;
        checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== d || rsp_err !== 1'b0) begin failures++; $display("FAIL to_next_rsp got=%0h/%0h/%0h exp=2/%0h/0", rsp_valid, rsp_rdata, rsp_err, d); end
    endtask

    task automatic test_slverr;
        tick();
        req_write[1]     = 1'b1;
        req_addr[63:32]  = $urandom;
        req_wdata[63:32] = $urandom;
        req_valid        = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL err_grant got=%0h exp=2", req_ready); end
        tick();
        req_valid = '0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b1;
        PRDATA    = $urandom;
        #1;
        checks++; if (PWRITE !== 1'b1 || PWDATA !== req_wdata[63:32]) begin failures++; $display("FAIL err_setup_bus got=%0h/%0h exp=1/%0h", PWRITE, PWDATA, req_wdata[63:32]); end
        tick();
        #1;
        tick();
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        #1;
        checks++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL err_rsp got=%0h/%0h/%0h exp=2/1/0", rsp_valid, rsp_err, rsp_rdata); end
        tick();
        #1;
        checks++; if (rsp_valid !== 4'b0 || rsp_err !== 1'b1) begin failures++; $display("FAIL err_hold got=%0h/%0h exp=0/1", rsp_valid, rsp_err); end
    endtask

    task automatic test_reset_mid;
        tick();
        req_write[3]     = 1'b0;
        req_addr[127:96] = $urandom;
        req_valid        = 4'b1000;
        PREADY           = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rst_grant got=%0h exp=8", req_ready); end
        tick();
        req_valid = '0;
        #1;
        tick();
        #1;
        checks++; if (PENABLE !== 1'b1) begin failures++; $display("FAIL rst_access got=%0h exp=1", PENABLE); end
        PRESET = 1'b1;
        #1;
        checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin failures++; $display("FAIL rst_async got=%0h/%0h exp=0/0", PSEL, PENABLE); end
        tick();
        PREADY = 1'b1;
        #1;
        checks++; if (rsp_valid !== 4'b0 || PSEL !== 1'b0) begin failures++; $display("FAIL rst_no_rsp got=%0h/%0h exp=0/0", rsp_valid, PSEL); end
        PRESET = 1'b0;
        PREADY = 1'b0;
        tick();
        req_write[0]    = 1'b1;
        req_addr[31:0]  = $urandom;
        req_wdata[31:0] = $urandom;
        req_valid       = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rst_prio got=%0h exp=1", req_ready); end
        tick();
        req_valid = '0;
        PREADY    = 1'b1;
        #1;
        checks++; if (PADDR !== req_addr[31:0] || rsp_valid !== 4'b0) begin failures++; $display("FAIL rst_next_setup got=%0h/%0h exp=%0h/0", PADDR, rsp_valid, req_addr[31:0]); end
        tick();
        #1;
        tick();
        PREADY = 1'b0;
        #1;
        checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0) begin failures++; $display("FAIL rst_next_rsp got=%0h/%0h exp=1/0", rsp_valid, rsp_err); end
    endtask

    // Model tracks which transfer is on the bus, how many ACCESS cycles it has
    // seen, and which response is owed next cycle.
    task automatic test_random;
        logic [3:0]  clr;
        logic [3:0]  exp_ready;
        int          ptr;
        int          phase;
        int          acc;
        int          waits;
        int          cur;
        int          g;
        bit          found;
        bit          comp;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_write;
        bit          rv;
        int          rwho;
        logic [31:0] rrd;
        logic        rerr;
        PRESET = 1'b1;
        clear_inputs();
        tick();
        PRESET  = 1'b0;
        ptr     = NREQ - 1;
        phase   = 0;
        acc     = 0;
        waits   = 0;
        cur     = 0;
        rv      = 0;
        rwho    = 0;
        rrd     = '0;
        rerr    = 1'b0;
        clr     = '0;
        e_addr  = '0;
        e_wdata = '0;
        e_write = 1'b0;
        for (int c = 0; c < 800; c++) begin
            tick();
            req_valid = req_valid & ~clr;
            clr       = '0;
            if (c < 760) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                        req_valid[i]          = 1'b1;
                        req_write[i]          = 1'($urandom_range(0, 1));
                        req_addr[i*AW +: AW]  = $urandom;
                        req_wdata[i*DW +: DW] = $urandom;
                    end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            PRDATA  = $urandom;
            PSLVERR = ($urandom_range(0, 3) == 0);
            PREADY  = (phase == 2) ? (acc == waits) : 1'($urandom_range(0, 1));
            #1;
            checks++; if (rsp_valid !== (rv ? 4'(1 << rwho) : 4'b0)) begin failures++; $display("FAIL rnd_rsp_valid c=%0d got=%0h exp=%0h", c, rsp_valid, rv ? 4'(1 << rwho) : 4'b0); end
            if (rv) begin
                checks++; if (rsp_rdata !== rrd || rsp_err !== rerr) begin failures++; $display("FAIL rnd_rsp_data c=%0d got=%0h/%0h exp=%0h/%0h", c, rsp_rdata, rsp_err, rrd, rerr); end
            end
            rv = 0;
            checks++; if (PSEL !== (phase != 0) || PENABLE !== (phase == 2)) begin failures++; $display("FAIL rnd_phase c=%0d got=%0h/%0h exp=%0h/%0h", c, PSEL, PENABLE, phase != 0, phase == 2); end
            if (phase != 0) begin
                checks++; if (PADDR !== e_addr || PWRITE !== e_write || PWDATA !== (e_write ? e_wdata : 32'h0)) begin failures++; $display("FAIL rnd_bus c=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", c, PADDR, PWRITE, PWDATA, e_addr, e_write, e_write ? e_wdata : 32'h0); end
            end
            comp = 0;
            if (phase == 2 && (PREADY || acc == TO - 1)) begin
                comp = 1;
                rv   = 1;
                rwho = cur;
                rrd  = PREADY ? (e_write ? 32'h0 : PRDATA) : 32'h0;
                rerr = PREADY ? PSLVERR : 1'b1;
            end
            exp_ready = '0;
            if ((phase == 0 || comp) && req_valid != 4'b0) begin
                found = 0;
                g     = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!found && req_valid[(ptr + k) % NREQ]) begin
                        found = 1;
                        g     = (ptr + k) % NREQ;
                    end
                end
                exp_ready = 4'(1 << g);
                ptr       = g;
                cur       = g;
                e_addr    = req_addr[g*AW +: AW];
                e_wdata   = req_wdata[g*DW +: DW];
                e_write   = req_write[g];
                clr       = exp_ready;
                phase     = 1;
            end else if (comp) begin
                phase = 0;
            end else if (phase == 1) begin
                phase = 2;
                acc   = 0;
                waits = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
            end else if (phase == 2) begin
                acc++;
            end
            checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rnd_req_ready c=%0d got=%0h exp=%0h", c, req_ready, exp_ready); end
        end
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_back_to_back();
        test_timeout();
        test_slverr();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_gpio_master_arb.md
Name: apb_gpio_master_arb

Overview:
- Round-robin arbiter and APB master sequencer that shares one APB port to the GPIO slave among NREQ on-chip requesters.
- Accepts one request at a time, runs a compliant SETUP/ACCESS transfer with wait-state support and a timeout, and returns read data and error status to the winning requester.
- Sits between the internal requesters (CPU shim, DMA, test port) and the GPIO APB slave.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 32, APB address width
- DW, 32, APB data width
- TIMEOUT, 16, max ACCESS cycles without PREADY before abort (>=2)

Ports:
- PCLK  in  1  APB clock, rising edge
- PRESET  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  per-requester request; held until accepted
- req_ready  out  NREQ  one-hot accept, combinational, one cycle
- req_write  in  NREQ  1=write, 0=read, per requester
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data; requester i at [i*DW +: DW]
- rsp_valid  out  NREQ  one-hot completion pulse, registered
- rsp_rdata  out  DW  read data (0 for writes and timeouts)
- rsp_err  out  1  PSLVERR or timeout, qualified by rsp_valid
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  AW  APB address
- PWDATA  out  DW  APB write data (0 on reads)
- PRDATA  in  DW  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- Reset (async, PRESET=1):
  - State IDLE; all outputs 0.
  - Timeout counter 0.
  - Round-robin pointer last_grant=NREQ-1, so requester 0 has first priority.
- FSM IDLE / SETUP / ACCESS:
  - IDLE: if any req_valid, grant g = first valid index searching from last_grant+1 with wrap.
    - Assert req_ready[g] this cycle; latch write/addr/wdata of g; last_grant<=g; next SETUP.
  - SETUP: PSEL=1, PENABLE=0 for exactly one cycle; next ACCESS; counter cleared.
  - ACCESS: PSEL=1, PENABLE=1.
    - PREADY=1: transfer completes. Capture PRDATA (reads only, else 0) and PSLVERR. Next cycle rsp_valid[g]=1 for one cycle with captured rsp_rdata/rsp_err.
    - PREADY=0: counter++.
    - Counter reaches TIMEOUT-1 with PREADY=0: abort. Next cycle PSEL=PENABLE=0 and rsp_valid[g]=1, rsp_err=1, rsp_rdata=0.
- Back-to-back: in the completing ACCESS cycle (PREADY=1 or abort), if any req_valid, arbitrate as in IDLE (req_ready same cycle) and go directly to SETUP. Otherwise go to IDLE.
  - PENABLE is always 0 the cycle after PREADY=1.
- Stability: PADDR/PWRITE/PWDATA change only on entry to SETUP; stable through SETUP and all ACCESS wait states.
  - PSEL never drops between SETUP and ACCESS; PENABLE=1 implies PSEL=1.
- PSEL=0 outside SETUP/ACCESS. PADDR/PWRITE/PWDATA hold their last values while idle.
- rsp_rdata and rsp_err hold their values until the next rsp_valid.
- A requester whose req_valid drops before req_ready is simply not granted; no partial state is kept.
- Same requester may be granted consecutively only if no other requester is valid.
- Reset asserted mid-transfer: transfer is dropped immediately, no rsp_valid, PSEL/PENABLE=0 asynchronously.
- Latency: request in IDLE at cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> zero-wait completion -> rsp_valid cycle 3.

Test Plan:
- Single write, req0 addr=0x04 wdata=0xA5A5_0001, PREADY=1 at ACCESS: req_ready[0] at c0; PSEL c1-c2, PENABLE c2; rsp_valid=4'b0001 at c3, rsp_err=0.
- Read with 3 wait states, req2 addr=0x08, PRDATA=0x0000_00FF on the PREADY cycle: PADDR stable over 5 PSEL cycles; rsp_rdata=0xFF, rsp_valid=4'b0100.
- All four requesters valid continuously, zero-wait slave: grants 0,1,2,3,0 in order; each transfer 2 PSEL cycles, no idle gap; PENABLE=0 after every PREADY.
- PREADY held 0: abort after TIMEOUT=16 ACCESS cycles; PSEL falls the next cycle; rsp_err=1, rsp_rdata=0; the next request proceeds normally.
- PSLVERR=1 with PREADY=1 on a write by req1: rsp_valid=4'b0010, rsp_err=1.
- PRESET pulsed during the ACCESS of a req3 read: PSEL/PENABLE go 0 immediately, no rsp_valid; after release, req0 is granted first when req0 and req3 are both valid.
